edge_scan_ctrl: RTL and testbench
=================================

Name: edge_scan_ctrl

Overview:
- Sequencer for the edge-detection datapath.
- After a frame is loaded into the image register file, it steps the operation chain MED_FIL -> GAU_FIL -> SOBEL -> NON_MAX -> HYSTER.
- For each operation it raster-scans the KxK kernel window over the IMG_DIM x IMG_DIM image, issuing one window column of register-file read indices per cycle.
- It tracks the filter pipeline latency to produce write indices and write-back/readable strobes. It owns no pixel data.

Parameters:
IMG_DIM, 20, image side length in pixels
IDX_W, 9, width of a register-file index (must hold IMG_DIM*IMG_DIM-1)
MOD_LAT, 2, cycles from an accepted column to the filter output for the window it completes (>=1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
load_end  input  1  frame fully loaded; starts the operation chain
mod_ready  input  1  datapath accepts the issued column this cycle
op  output  3  current operation: 0 IDLE, 1 MED_FIL, 2 GAU_FIL, 3 SOBEL, 4 NON_MAX, 5 HYSTER
col_valid  output  1  rd_idx0..4 carry a valid window column
col_first  output  1  issued column is column 0 of a window row; datapath flushes its window
rd_idx0..rd_idx4  output  IDX_W each  register-file indices of the column rows, top to bottom
wr_valid  output  1  filter output valid this cycle
wr_idx  output  IDX_W  image-space index of the window centre for the current output
wb_en  output  1  one-cycle pulse: copy tmp results into the image register file
readable  output  1  edge_out valid (wr_valid during HYSTER)
frame_done  output  1  one-cycle pulse: chain finished

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE, op=0, row=col=0, delay line cleared. All outputs 0.
- Reset taken in any state, including mid-scan, aborts the frame with no further strobes.
- Kernel size K: 5 for GAU_FIL, 3 otherwise.
- Window top row r runs 0..IMG_DIM-K. Column c runs 0..IMG_DIM-1.
- States and transitions:
  - IDLE: on load_end=1 go to SET_OP.
  - SET_OP (1 cycle): op advances IDLE->1->2->3->4->5. row=0, col=0. Go to SCAN.
  - SCAN: col_valid=1.
    - rd_idxk = (r+k)*IMG_DIM + c for k<K; unused rd_idx = 0.
    - col_first = (c==0).
    - Indices advance only on a cycle with mod_ready=1. When mod_ready=0, all column outputs hold stable.
    - After acceptance: c wraps to 0 and r increments when c==IMG_DIM-1.
    - Acceptance of r=IMG_DIM-K, c=IMG_DIM-1 goes to DRAIN.
  - DRAIN: col_valid=0. Stay MOD_LAT cycles. Then go to DONE if op==5, else WRITE_BACK.
  - WRITE_BACK (1 cycle): wb_en=1. Go to SET_OP.
  - DONE (1 cycle): frame_done=1, op=0. Go to IDLE.
- load_end is ignored outside IDLE.
- Output tracking:
  - An accepted column with c>=K-1 completes a window.
  - Push (1, (r+K/2)*IMG_DIM + (c-K/2)) into a MOD_LAT-deep delay line. Other accepted columns and stall cycles push (0, 0).
  - The line shifts every cycle, independent of mod_ready.
  - wr_valid and wr_idx are the line output. readable = wr_valid & (op==5).
- Counts: accepted columns per op = (IMG_DIM-K+1)*IMG_DIM, i.e. 360 for K=3 and 320 for K=5 at default. wr_valid count per op = (IMG_DIM-K+1)^2.
- All arithmetic is unsigned, IDX_W bits; no overflow occurs for legal parameters.

Decomposition:
- Shared package edge_pkg: IMG_DIM, IDX_W, op encodings (IDLE, MED_FIL..HYSTER, QUANTIZE=6 reserved), kernel-size function of op.
- Sub-module edge_lat_pipe: MOD_LAT-deep valid+index delay line with synchronous clear.
- The FSM and the r/c counters stay in edge_scan_ctrl.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-stimulus -> every output 0, op=0. load_end asserted during reset has no effect.
- Start with mod_ready=1:
  - load_end pulse -> op=1 the cycle after SET_OP.
  - First column rd_idx0..2 = 0,20,40, col_first=1, rd_idx3/4 = 0.
  - First wr_valid 2 cycles after c=2 is accepted, wr_idx=21.
  - Last MED_FIL wr_idx=378.
- GAU_FIL:
  - First column rd_idx0..4 = 0,20,40,60,80.
  - First wr_idx=42, last wr_idx=357.
  - 320 accepted columns and 256 wr_valid.
- Stall: drop mod_ready for 5 cycles at r=3, c=7 -> rd_idx frozen at 67,87,107. Column total is still 360 and wr_valid total still 324.
- Full frame with mod_ready=1:
  - op sequence 1,2,3,4,5.
  - wb_en pulses exactly 4 times.
  - readable high 324 cycles.
  - frame_done once, then IDLE.
  - load_end pulsed during SCAN is ignored.
- Reset mid-scan: reset=0 during SOBEL at r=10 -> next cycle IDLE, no wr_valid, wb_en or frame_done afterwards. A new load_end restarts at op=1, r=0.

Source files
------------

// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared geometry, op encodings and kernel size for the edge-detection sequencer
package edge_pkg;

  localparam int IMG_DIM = 20;
  localparam int IDX_W   = 9;

  typedef enum logic [2:0] {
    OP_IDLE     = 3'd0,
    OP_MED_FIL  = 3'd1,
    OP_GAU_FIL  = 3'd2,
    OP_SOBEL    = 3'd3,
    OP_NON_MAX  = 3'd4,
    OP_HYSTER   = 3'd5,
    OP_QUANTIZE = 3'd6
  } op_e;

  function automatic logic [IDX_W-1:0] kernel_size(input op_e op);
    return (op == OP_GAU_FIL) ? IDX_W'(5) : IDX_W'(3);
  endfunction

endpackage

// File: rtl/edge_lat_pipe.sv
// rtl/edge_lat_pipe.sv - fixed-depth valid+index delay line matching the filter pipeline latency
module edge_lat_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  input  logic [W-1:0] in_idx,
  output logic         out_valid,
  output logic [W-1:0] out_idx
);

  logic         valid_q [DEPTH];
  logic         valid_d [DEPTH];
  logic [W-1:0] idx_q   [DEPTH];
  logic [W-1:0] idx_d   [DEPTH];

  always_comb begin
    valid_d[0] = in_valid;
    idx_d[0]   = in_idx;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      idx_d[i]   = idx_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        idx_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= valid_d[i];
        idx_q[i]   <= idx_d[i];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/edge_scan_ctrl.sv
// rtl/edge_scan_ctrl.sv - steps the filter chain and raster-scans kernel window columns per operation
module edge_scan_ctrl
  import edge_pkg::*;
#(
  parameter int MOD_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_end,
  input  logic             mod_ready,
  output logic [2:0]       op,
  output logic             col_valid,
  output logic             col_first,
  output logic [IDX_W-1:0] rd_idx0,
  output logic [IDX_W-1:0] rd_idx1,
  output logic [IDX_W-1:0] rd_idx2,
  output logic [IDX_W-1:0] rd_idx3,
  output logic [IDX_W-1:0] rd_idx4,
  output logic             wr_valid,
  output logic [IDX_W-1:0] wr_idx,
  output logic             wb_en,
  output logic             readable,
  output logic             frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SET_OP, S_SCAN, S_DRAIN, S_WRITE_BACK, S_DONE
  } state_e;

  localparam int LAT_W = $clog2(MOD_LAT + 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [IDX_W-1:0] row_q, row_d, col_q, col_d;
  logic [LAT_W-1:0] drain_q, drain_d;
  logic [IDX_W-1:0] k, half, push_idx;
  logic [IDX_W-1:0] rd_idx [5];
  logic             in_scan, accept, push_valid, last_col, last_row;

  always_comb begin
    k          = kernel_size(op_q);
    half       = k >> 1;
    in_scan    = (state_q == S_SCAN);
    accept     = in_scan && mod_ready;
    last_col   = (col_q == IDX_W'(IMG_DIM - 1));
    last_row   = (row_q == IDX_W'(IMG_DIM) - k);
    // A column at or beyond K-1 closes the window whose centre sits K/2 back.
    push_valid = accept && (col_q >= k - IDX_W'(1));
    push_idx   = push_valid ? (row_q + half) * IDX_W'(IMG_DIM) + col_q - half : '0;
    for (int i = 0; i < 5; i++) begin
      rd_idx[i] = (in_scan && IDX_W'(i) < k) ? (row_q + IDX_W'(i)) * IDX_W'(IMG_DIM) + col_q : '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    row_d      = row_q;
    col_d      = col_q;
    drain_d    = drain_q;
    col_valid  = 1'b0;
    col_first  = 1'b0;
    wb_en      = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load_end) state_d = S_SET_OP;
      end
      S_SET_OP: begin
        op_d    = op_e'(op_q + 3'd1);
        row_d   = '0;
        col_d   = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        col_valid = 1'b1;
        col_first = (col_q == '0);
        if (accept) begin
          if (last_col) begin
            col_d = '0;
            row_d = row_q + IDX_W'(1);
            if (last_row) begin
              state_d = S_DRAIN;
              drain_d = '0;
            end
          end else begin
            col_d = col_q + IDX_W'(1);
          end
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + LAT_W'(1);
        if (drain_q == LAT_W'(MOD_LAT - 1)) begin
          if (op_q == OP_HYSTER) begin
            state_d = S_DONE;
            op_d    = OP_IDLE;
          end else begin
            state_d = S_WRITE_BACK;
          end
        end
      end
      S_WRITE_BACK: begin
        wb_en   = 1'b1;
        state_d = S_SET_OP;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      row_q   <= row_d;
      col_q   <= col_d;
      drain_q <= drain_d;
    end
  end

  edge_lat_pipe #(
    .DEPTH (MOD_LAT),
    .W     (IDX_W)
  ) u_lat_pipe (
    .clk       (clk),
    .resetn    (reset),
    .in_valid  (push_valid),
    .in_idx    (push_idx),
    .out_valid (wr_valid),
    .out_idx   (wr_idx)
  );

  assign op       = op_q;
  assign readable = wr_valid && (op_q == OP_HYSTER);
  assign rd_idx0  = rd_idx[0];
  assign rd_idx1  = rd_idx[1];
  assign rd_idx2  = rd_idx[2];
  assign rd_idx3  = rd_idx[3];
  assign rd_idx4  = rd_idx[4];

endmodule

// File: tb/tb_edge_scan_ctrl.sv
// tb/tb_edge_scan_ctrl.sv - randomized self-checking bench for edge_scan_ctrl against a schedule model
module tb_edge_scan_ctrl;

  localparam int IMG = 20;
  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       reset, load_end, mod_ready;
  logic [2:0] op;
  logic       col_valid, col_first, wr_valid, wb_en, readable, frame_done;
  logic [8:0] rd_idx0, rd_idx1, rd_idx2, rd_idx3, rd_idx4, wr_idx;

  always #5 clk = ~clk;

  edge_scan_ctrl #(.MOD_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .load_end(load_end), .mod_ready(mod_ready),
    .op(op), .col_valid(col_valid), .col_first(col_first),
    .rd_idx0(rd_idx0), .rd_idx1(rd_idx1), .rd_idx2(rd_idx2), .rd_idx3(rd_idx3), .rd_idx4(rd_idx4),
    .wr_valid(wr_valid), .wr_idx(wr_idx), .wb_en(wb_en), .readable(readable), .frame_done(frame_done)
  );

  typedef struct { int op; int r; int c; } col_t;

  int   checks = 0, failures = 0, cyc = 0;
  col_t cols[$];
  int   wins[$];
  int   exp_wr[int], exp_wr_op[int];
  bit   exp_wb[int], exp_fd[int], scan_start[int];
  bit   scan_active = 0, busy = 0;
  int   acc_cnt[8], wr_cnt[8], first_wr[8], last_wr[8];
  bit   first_seen[8];
  int   readable_cnt = 0, wb_cnt = 0, fd_cnt = 0, last_op = 0;
  int   op_seq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int ksize(input int o);
    return (o == 2) ? 5 : 3;
  endfunction

  function automatic logic [63:0] exp_col(input col_t e);
    logic [63:0] v;
    v = 64'(e.op);
    v = (v << 1) | 64'(e.c == 0);
    for (int i = 0; i < 5; i++) v = (v << 9) | 64'((i < ksize(e.op)) ? (e.r + i) * IMG + e.c : 0);
    return v;
  endfunction

  // Whole-frame expectation: every column in raster order, and every window centre in order.
  task automatic fill_model();
    for (int o = 1; o <= 5; o++) begin
      int kk = ksize(o);
      int hh = kk / 2;
      for (int r = 0; r <= IMG - kk; r++)
        for (int c = 0; c < IMG; c++) cols.push_back('{o, r, c});
      for (int r = 0; r <= IMG - kk; r++)
        for (int c = 0; c <= IMG - kk; c++) wins.push_back((r + hh) * IMG + c + hh);
    end
  endtask

  col_t cur;
  int   kk_m, ewi, eop;
  bit   ev, ed;

  always @(negedge clk) begin
    if (scan_start.exists(cyc)) begin
      scan_active = 1;
      scan_start.delete(cyc);
    end
    check("col_valid", 64'(col_valid), 64'(scan_active));
    if (scan_active && col_valid === 1'b1) begin
      if (cols.size() == 0) begin
        check("col_extra", 64'(col_valid), 64'(0));
      end else begin
        cur  = cols[0];
        kk_m = ksize(cur.op);
        check("col", {15'd0, op, col_first, rd_idx0, rd_idx1, rd_idx2, rd_idx3, rd_idx4}, exp_col(cur));
        if (mod_ready) begin
          void'(cols.pop_front());
          if (cur.c >= kk_m - 1) begin
            exp_wr[cyc + LAT]    = wins.pop_front();
            exp_wr_op[cyc + LAT] = cur.op;
          end
          if (cur.r == IMG - kk_m && cur.c == IMG - 1) begin
            scan_active = 0;
            if (cur.op == 5) exp_fd[cyc + LAT + 1] = 1;
            else begin
              exp_wb[cyc + LAT + 1]     = 1;
              scan_start[cyc + LAT + 3] = 1;
            end
          end
        end
      end
    end
    ev  = exp_wr.exists(cyc);
    ewi = ev ? exp_wr[cyc] : 0;
    eop = ev ? exp_wr_op[cyc] : 0;
    check("wr", 64'({wr_valid, wr_idx}), 64'({ev, 9'(ewi)}));
    check("readable", 64'(readable), 64'(ev && eop == 5));
    check("wb_en", 64'(wb_en), 64'(exp_wb.exists(cyc)));
    ed = exp_fd.exists(cyc);
    check("frame_done", 64'(frame_done), 64'(ed));
    if (ed) check("done_op", 64'(op), 64'(0));
    exp_wr.delete(cyc); exp_wr_op.delete(cyc); exp_wb.delete(cyc); exp_fd.delete(cyc);

    if (col_valid && mod_ready) acc_cnt[op]++;
    if (wr_valid) begin
      wr_cnt[op]++;
      if (!first_seen[op]) first_wr[op] = int'(wr_idx);
      first_seen[op] = 1;
      last_wr[op] = int'(wr_idx);
    end
    if (readable) readable_cnt++;
    if (wb_en) wb_cnt++;
    if (frame_done) fd_cnt++;
    if (int'(op) != last_op) begin
      if (op != 3'd0) op_seq.push_back(int'(op));
      last_op = int'(op);
    end

    if (reset === 1'b0) begin
      cols.delete(); wins.delete();
      exp_wr.delete(); exp_wr_op.delete(); exp_wb.delete(); exp_fd.delete(); scan_start.delete();
      scan_active = 0;
      busy = 0;
    end else if (load_end && !busy) begin
      busy = 1;
      fill_model();
      scan_start[cyc + 2] = 1;
    end
    if (ed) busy = 0;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 8; i++) begin
      acc_cnt[i] = 0; wr_cnt[i] = 0; first_seen[i] = 0; first_wr[i] = 0; last_wr[i] = 0;
    end
    readable_cnt = 0; wb_cnt = 0; fd_cnt = 0;
    op_seq.delete();
  endtask

  task automatic run_frame(input bit rnd, input bit do_stall, input bit do_rst, input int budget);
    int n = 0, stall_left = 0;
    bit stalled = 0, rst_done = 0;
    while (fd_cnt == 0 && n < budget && !rst_done) begin
      mod_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      load_end  = rnd ? ($urandom_range(0, 50) == 0) : (op == 3'd2 && col_valid && rd_idx0 == 9'd5);
      if (do_stall && !stalled && op == 3'd1 && col_valid && rd_idx0 == 9'd67) begin
        stalled = 1;
        stall_left = 5;
      end
      if (stall_left > 0) begin
        mod_ready = 1'b0;
        check("stall_hold", 64'({rd_idx0, rd_idx1, rd_idx2}), 64'({9'd67, 9'd87, 9'd107}));
        stall_left--;
      end
      if (do_rst && op == 3'd3 && col_valid && rd_idx0 == 9'd200) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
        load_end = 1'b0;
        rst_done = 1;
        check("mid_rst_ctrl", 64'({op, col_valid, col_first, wr_valid, wb_en, readable, frame_done}), 64'(0));
        check("mid_rst_idx", 64'({rd_idx0, rd_idx1, rd_idx2, rd_idx3, rd_idx4, wr_idx}), 64'(0));
      end else begin
        tick();
      end
      n++;
    end
    load_end = 1'b0;
    if (do_rst) check("rst_trigger_seen", 64'(rst_done), 64'(1));
    else check("frame_done_in_budget", 64'(fd_cnt), 64'(1));
    if (do_stall) check("stall_applied", 64'(stalled), 64'(1));
  endtask

  task automatic check_frame();
    int exp_acc[5] = '{360, 320, 360, 360, 360};
    int exp_wrc[5] = '{324, 256, 324, 324, 324};
    for (int o = 1; o <= 5; o++) begin
      check($sformatf("acc_cnt_op%0d", o), 64'(acc_cnt[o]), 64'(exp_acc[o-1]));
      check($sformatf("wr_cnt_op%0d", o), 64'(wr_cnt[o]), 64'(exp_wrc[o-1]));
    end
    check("readable_cnt", 64'(readable_cnt), 64'(324));
    check("wb_cnt", 64'(wb_cnt), 64'(4));
    check("fd_cnt", 64'(fd_cnt), 64'(1));
    check("op_seq_len", 64'(op_seq.size()), 64'(5));
    for (int i = 0; i < op_seq.size() && i < 5; i++) check("op_seq", 64'(op_seq[i]), 64'(i + 1));
    check("cols_left", 64'(cols.size()), 64'(0));
    check("wins_left", 64'(wins.size()), 64'(0));
  endtask

  initial begin
    reset = 1'b0; load_end = 1'b1; mod_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b1; load_end = 1'b0;
    tick();
    check("rst_ctrl", 64'({op, col_valid, col_first, wr_valid, wb_en, readable, frame_done}), 64'(0));
    check("rst_idx", 64'({rd_idx0, rd_idx1, rd_idx2, rd_idx3, rd_idx4, wr_idx}), 64'(0));
    repeat (5) tick();
    check("idle_after_rst", 64'({op, col_valid}), 64'(0));

    clear_counts();
    load_end = 1'b1;
    tick();
    run_frame(1'b0, 1'b1, 1'b0, 6000);
    check_frame();
    check("med_first_wr", 64'(first_wr[1]), 64'(21));
    check("med_last_wr", 64'(last_wr[1]), 64'(378));
    check("gau_first_wr", 64'(first_wr[2]), 64'(42));
    check("gau_last_wr", 64'(last_wr[2]), 64'(357));
    tick();
    check("idle_after_done", 64'({op, col_valid}), 64'(0));

    clear_counts();
    load_end = 1'b1;
    tick();
    run_frame(1'b1, 1'b0, 1'b0, 8000);
    check_frame();

    clear_counts();
    load_end = 1'b1;
    tick();
    run_frame(1'b1, 1'b0, 1'b1, 8000);
    clear_counts();
    repeat (40) begin
      mod_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("post_rst_wr", 64'(wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3] + wr_cnt[4] + wr_cnt[5]), 64'(0));
    check("post_rst_wb", 64'(wb_cnt), 64'(0));
    check("post_rst_fd", 64'(fd_cnt), 64'(0));

    clear_counts();
    load_end = 1'b1;
    tick();
    run_frame(1'b1, 1'b0, 1'b0, 8000);
    check_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
